// File: rtl/toeplitz_row_gen_pkg.sv
// Shared constants and state encoding for the Toeplitz row generator and its
// companion XOR accumulator.
package toeplitz_row_gen_pkg;

    localparam int ROW_W_DEF  = 3072;
    localparam int N_ROWS_DEF = 4096;
    localparam int SEED_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        EMIT  = 3'd2,
        SHIFT = 3'd3,
        FETCH = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Number of seed words needed to fill the first row.
    function automatic int load_words(input int row_w, input int seed_w);
        return row_w / seed_w;
    endfunction

    // Total seed words consumed per matrix: the initial fill plus one new
    // bit for every row after the first, rounded up to whole words.
    function automatic int matrix_words(input int row_w, input int n_rows, input int seed_w);
        return (row_w / seed_w) + ((n_rows - 1 + seed_w - 1) / seed_w);
    endfunction

    localparam int LOAD_WORDS_DEF   = load_words(ROW_W_DEF, SEED_W_DEF);
    localparam int MATRIX_WORDS_DEF = matrix_words(ROW_W_DEF, N_ROWS_DEF, SEED_W_DEF);

endpackage

// File: rtl/toeplitz_row_gen.sv
// Expands a serial seed stream into successive Toeplitz matrix rows and pushes
// them into the accumulator's row FIFO. Row k bit j equals seed bit (k+j).
module toeplitz_row_gen
    import toeplitz_row_gen_pkg::*;
#(
    parameter int ROW_W  = ROW_W_DEF,
    parameter int N_ROWS = N_ROWS_DEF,
    parameter int SEED_W = SEED_W_DEF
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              gen_en,
    input  logic              seed_valid,
    input  logic [SEED_W-1:0] seed_data,
    output logic              seed_ready,
    input  logic              fifo_full,
    output logic              fifo_write,
    output logic [ROW_W-1:0]  row,
    output logic              sum_en,
    output logic              done
);

    localparam int LOAD_WORDS = load_words(ROW_W, SEED_W);
    localparam int WC_W       = $clog2(LOAD_WORDS) + 1;
    localparam int RC_W       = $clog2(N_ROWS) + 1;
    localparam int BL_W       = $clog2(SEED_W) + 1;

    state_t            state_reg;
    logic [WC_W-1:0]   word_cnt_reg;
    logic [RC_W-1:0]   row_cnt_reg;
    logic [BL_W-1:0]   bits_left_reg;
    logic [SEED_W-1:0] bitbuf_reg;
    logic [ROW_W-1:0]  load_next;

    // Whole-word load: the new word enters at the top so that after the last
    // fill word, bit j of the row holds seed bit j.
    generate
        if (ROW_W > SEED_W) begin : g_load_wide
            assign load_next = {seed_data, row[ROW_W-1:SEED_W]};
        end else begin : g_load_single
            assign load_next = seed_data;
        end
    endgenerate

    // Control FSM with registered outputs, row shift register, bit buffer and counters.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            word_cnt_reg  <= '0;
            row_cnt_reg   <= '0;
            bits_left_reg <= '0;
            bitbuf_reg    <= '0;
            row           <= '0;
            seed_ready    <= 1'b0;
            fifo_write    <= 1'b0;
            sum_en        <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    word_cnt_reg  <= '0;
                    row_cnt_reg   <= '0;
                    bits_left_reg <= '0;
                    bitbuf_reg    <= '0;
                    fifo_write    <= 1'b0;
                    sum_en        <= 1'b0;
                    done          <= 1'b0;
                    seed_ready    <= 1'b0;
                    if (gen_en) begin
                        seed_ready <= 1'b1;
                        state_reg  <= LOAD;
                    end
                end
                LOAD: begin
                    if (seed_valid) begin
                        row <= load_next;
                        if (word_cnt_reg == WC_W'(LOAD_WORDS - 1)) begin
                            word_cnt_reg <= '0;
                            seed_ready   <= 1'b0;
                            state_reg    <= EMIT;
                        end else begin
                            word_cnt_reg <= word_cnt_reg + WC_W'(1);
                        end
                    end
                end
                EMIT: begin
                    // Backpressure is honoured only here, before the strobe,
                    // so a pushed row is never retracted or repeated.
                    if (!fifo_full) begin
                        fifo_write <= 1'b1;
                        sum_en     <= (row_cnt_reg == '0);
                        state_reg  <= SHIFT;
                    end
                end
                SHIFT: begin
                    fifo_write  <= 1'b0;
                    sum_en      <= 1'b0;
                    row_cnt_reg <= row_cnt_reg + RC_W'(1);
                    if (row_cnt_reg == RC_W'(N_ROWS - 1)) begin
                        state_reg <= DONE;
                    end else if (bits_left_reg != '0) begin
                        row           <= {bitbuf_reg[0], row[ROW_W-1:1]};
                        bitbuf_reg    <= bitbuf_reg >> 1;
                        bits_left_reg <= bits_left_reg - BL_W'(1);
                        state_reg     <= EMIT;
                    end else begin
                        // Buffer empty: fetch a new word only when another row
                        // is still needed, so no surplus words are consumed.
                        seed_ready <= 1'b1;
                        state_reg  <= FETCH;
                    end
                end
                FETCH: begin
                    if (seed_valid) begin
                        row           <= {seed_data[0], row[ROW_W-1:1]};
                        bitbuf_reg    <= seed_data >> 1;
                        bits_left_reg <= BL_W'(SEED_W - 1);
                        seed_ready    <= 1'b0;
                        state_reg     <= EMIT;
                    end
                end
                DONE: begin
                    done      <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_toeplitz_row_gen.sv
// Self-checking bench for toeplitz_row_gen in a small configuration.
// Expected rows come from the seed bit stream directly: row k bit j = seed bit k+j.
module tb_toeplitz_row_gen;

    localparam int ROW_W      = 8;
    localparam int N_ROWS     = 4;
    localparam int SEED_W     = 4;
    localparam int LOAD_WORDS = ROW_W / SEED_W;
    localparam int EXP_WORDS  = LOAD_WORDS + (N_ROWS - 1 + SEED_W - 1) / SEED_W;
    localparam int MAX_CYC    = 400;

    logic              clk_in = 1'b0;
    logic              rst;
    logic              gen_en;
    logic              seed_valid;
    logic [SEED_W-1:0] seed_data;
    logic              seed_ready;
    logic              fifo_full;
    logic              fifo_write;
    logic [ROW_W-1:0]  row;
    logic              sum_en;
    logic              done;

    toeplitz_row_gen #(.ROW_W(ROW_W), .N_ROWS(N_ROWS), .SEED_W(SEED_W)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .gen_en     (gen_en),
        .seed_valid (seed_valid),
        .seed_data  (seed_data),
        .seed_ready (seed_ready),
        .fifo_full  (fifo_full),
        .fifo_write (fifo_write),
        .row        (row),
        .sum_en     (sum_en),
        .done       (done)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_bad = 0;

    logic [SEED_W-1:0] seed_words [0:15];
    logic [ROW_W-1:0]  rows_q [$];

    int sum_cnt, sum_first, sum_orphan, wr_full, words_taken;
    int done_at_writes, first_wr_cyc, load_acc_cyc, ready_first;
    bit timed_out;

    // Reference: row k is the ROW_W-bit window of the seed bit stream starting at bit k.
    function automatic logic [ROW_W-1:0] model_row(input int k);
        logic [ROW_W-1:0]  r;
        logic [SEED_W-1:0] w;
        int                b;
        r = '0;
        for (int j = 0; j < ROW_W; j++) begin
            b    = k + j;
            w    = seed_words[b / SEED_W];
            r[j] = w[b % SEED_W];
        end
        return r;
    endfunction

    task automatic set_nominal_seed();
        for (int i = 0; i < 16; i++) seed_words[i] = 4'hF;
        seed_words[0] = 4'hA;
        seed_words[1] = 4'h5;
        seed_words[2] = 4'h3;
    endtask

    task automatic set_random_seed();
        for (int i = 0; i < 16; i++) seed_words[i] = SEED_W'($urandom);
    endtask

    // Runs one matrix from IDLE, recording pushed rows and handshake events.
    // Called and returns just after a falling edge.
    task automatic drive_matrix(input int full_pct, input int stall_pct, input bit hold_gen);
        int cyc;
        int widx;
        bit acc;
        bit full_at_edge;
        bit first_obs;
        cyc = 0; widx = 0; first_obs = 1;
        rows_q.delete();
        sum_cnt = 0; sum_first = 0; sum_orphan = 0; wr_full = 0; words_taken = 0;
        done_at_writes = -1; first_wr_cyc = -1; load_acc_cyc = -1; ready_first = -1;
        timed_out = 0;
        gen_en = 1'b1;
        while (1) begin
            if (cyc >= MAX_CYC) begin
                timed_out = 1;
                break;
            end
            seed_data    = seed_words[widx];
            seed_valid   = ($urandom_range(99) >= stall_pct);
            fifo_full    = ($urandom_range(99) < full_pct);
            acc          = seed_valid && seed_ready;
            full_at_edge = fifo_full;
            @(posedge clk_in);
            if (acc) begin
                if (widx == LOAD_WORDS - 1) load_acc_cyc = cyc;
                if (widx < 15) widx++;
                words_taken++;
            end
            cyc++;
            @(negedge clk_in);
            if (!hold_gen) gen_en = 1'b0;
            if (first_obs) begin
                ready_first = int'(seed_ready);
                first_obs   = 0;
            end
            if (fifo_write) begin
                if (full_at_edge) wr_full++;
                rows_q.push_back(row);
                $display("  push %0d: row=%h sum_en=%0b cycle=%0d", rows_q.size() - 1, row, sum_en, cyc);
                if (rows_q.size() == 1) first_wr_cyc = cyc;
                if (sum_en) begin
                    sum_cnt++;
                    if (rows_q.size() == 1) sum_first = 1;
                end
            end else if (sum_en) begin
                sum_orphan++;
            end
            if (done) begin
                done_at_writes = rows_q.size();
                break;
            end
        end
        seed_valid = 1'b0;
        fifo_full  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; gen_en = 1'b0; seed_valid = 1'b0; seed_data = '0; fifo_full = 1'b0;
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        repeat (2) @(negedge clk_in);
        n_vec++;
        if ({seed_ready, fifo_write, sum_en, done} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 0000", {seed_ready, fifo_write, sum_en, done});
        end
        n_vec++;
        if (row !== '0) begin
            n_bad++;
            $display("FAIL reset_row: got %h want 00", row);
        end
    endtask

    task automatic test_nominal();
        logic [ROW_W-1:0] exp_rows [0:3];
        exp_rows = '{8'h5A, 8'hAD, 8'hD6, 8'h6B};
        set_nominal_seed();
        drive_matrix(0, 0, 1'b0);
        n_vec++;
        if (timed_out) begin n_bad++; $display("FAIL nominal_timeout: no done within %0d cycles", MAX_CYC); end
        n_vec++;
        if (rows_q.size() != N_ROWS) begin
            n_bad++; $display("FAIL nominal_count: got %0d writes want %0d", rows_q.size(), N_ROWS);
        end
        for (int k = 0; k < N_ROWS && k < rows_q.size(); k++) begin
            n_vec++;
            if (rows_q[k] !== exp_rows[k]) begin
                n_bad++; $display("FAIL nominal_row%0d: got %h want %h", k, rows_q[k], exp_rows[k]);
            end
        end
        n_vec++;
        if (sum_cnt != 1 || sum_first != 1 || sum_orphan != 0) begin
            n_bad++; $display("FAIL nominal_sum_en: got total=%0d first=%0d stray=%0d want 1 1 0", sum_cnt, sum_first, sum_orphan);
        end
        n_vec++;
        if (done_at_writes != N_ROWS) begin
            n_bad++; $display("FAIL nominal_done: got done after %0d writes want %0d", done_at_writes, N_ROWS);
        end
        n_vec++;
        if (first_wr_cyc - load_acc_cyc != 2) begin
            n_bad++; $display("FAIL nominal_latency: got %0d cycles want 2", first_wr_cyc - load_acc_cyc);
        end
    endtask

    task automatic test_seed_accounting();
        n_vec++;
        if (words_taken != EXP_WORDS) begin
            n_bad++; $display("FAIL words_consumed: got %0d want %0d", words_taken, EXP_WORDS);
        end
        // Offer a surplus word after completion; it must never be taken.
        seed_valid = 1'b1; seed_data = 4'hF; gen_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            n_vec++;
            if (seed_ready !== 1'b0 || done !== 1'b0) begin
                n_bad++; $display("FAIL extra_word_%0d: got ready=%b done=%b want 0 0", i, seed_ready, done);
            end
        end
        seed_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        for (int it = 0; it < 3; it++) begin
            set_random_seed();
            drive_matrix(60, 0, 1'b0);
            $display("backpressure matrix %0d: %0d rows", it, rows_q.size());
            n_vec++;
            if (timed_out || rows_q.size() != N_ROWS) begin
                n_bad++; $display("FAIL bp_count_%0d: got %0d writes timeout=%0d want %0d", it, rows_q.size(), timed_out, N_ROWS);
            end
            for (int k = 0; k < N_ROWS && k < rows_q.size(); k++) begin
                n_vec++;
                if (rows_q[k] !== model_row(k)) begin
                    n_bad++; $display("FAIL bp_row%0d_%0d: got %h want %h", k, it, rows_q[k], model_row(k));
                end
            end
            n_vec++;
            if (wr_full != 0) begin
                n_bad++; $display("FAIL bp_write_while_full_%0d: got %0d want 0", it, wr_full);
            end
        end
    endtask

    task automatic test_seed_stall();
        for (int it = 0; it < 3; it++) begin
            set_random_seed();
            drive_matrix(20, 60, 1'b0);
            $display("stall matrix %0d: %0d rows", it, rows_q.size());
            n_vec++;
            if (timed_out || rows_q.size() != N_ROWS || words_taken != EXP_WORDS) begin
                n_bad++; $display("FAIL stall_count_%0d: got %0d writes %0d words want %0d %0d", it, rows_q.size(), words_taken, N_ROWS, EXP_WORDS);
            end
            for (int k = 0; k < N_ROWS && k < rows_q.size(); k++) begin
                n_vec++;
                if (rows_q[k] !== model_row(k)) begin
                    n_bad++; $display("FAIL stall_row%0d_%0d: got %h want %h", k, it, rows_q[k], model_row(k));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int writes;
        int cyc;
        int widx;
        bit acc;
        writes = 0; cyc = 0; widx = 0;
        set_nominal_seed();
        gen_en = 1'b1;
        while (writes < 2 && cyc < MAX_CYC) begin
            seed_data = seed_words[widx]; seed_valid = 1'b1; fifo_full = 1'b0;
            acc = seed_valid && seed_ready;
            @(posedge clk_in);
            if (acc && widx < 15) widx++;
            cyc++;
            @(negedge clk_in);
            gen_en = 1'b0;
            if (fifo_write) writes++;
        end
        n_vec++;
        if (writes < 2) begin n_bad++; $display("FAIL midrst_timeout: got %0d writes want 2", writes); end
        seed_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({seed_ready, fifo_write, sum_en, done} !== 4'b0 || row !== '0) begin
            n_bad++; $display("FAIL midrst_async: got ctrl=%b row=%h want 0000 00", {seed_ready, fifo_write, sum_en, done}, row);
        end
        @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);
        drive_matrix(0, 0, 1'b0);
        n_vec++;
        if (timed_out || rows_q.size() != N_ROWS) begin
            n_bad++; $display("FAIL midrst_restart_count: got %0d want %0d", rows_q.size(), N_ROWS);
        end
        for (int k = 0; k < N_ROWS && k < rows_q.size(); k++) begin
            n_vec++;
            if (rows_q[k] !== model_row(k)) begin
                n_bad++; $display("FAIL midrst_row%0d: got %h want %h", k, rows_q[k], model_row(k));
            end
        end
    endtask

    task automatic test_back_to_back();
        set_random_seed();
        for (int m = 0; m < 2; m++) begin
            drive_matrix(30, 30, 1'b1);
            $display("back-to-back matrix %0d: %0d rows", m, rows_q.size());
            n_vec++;
            if (ready_first != 1) begin
                n_bad++; $display("FAIL b2b_start_%0d: seed_ready=%0d one cycle after start want 1", m, ready_first);
            end
            n_vec++;
            if (timed_out || rows_q.size() != N_ROWS || sum_cnt != 1 || sum_first != 1) begin
                n_bad++; $display("FAIL b2b_count_%0d: got %0d writes sum=%0d want %0d 1", m, rows_q.size(), sum_cnt, N_ROWS);
            end
            for (int k = 0; k < N_ROWS && k < rows_q.size(); k++) begin
                n_vec++;
                if (rows_q[k] !== model_row(k)) begin
                    n_bad++; $display("FAIL b2b_row%0d_%0d: got %h want %h", k, m, rows_q[k], model_row(k));
                end
            end
        end
        gen_en = 1'b0;
        @(negedge clk_in);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_seed_accounting();
        test_backpressure();
        test_seed_stall();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
